serial_mag_comparator: RTL

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

---
 rtl/serial_cmp_pkg.sv | 24 ++
 rtl/cmp2_slice.sv | 26 ++
 rtl/serial_mag_comparator.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmp_pkg
// Description : Shared types and constants for the serial magnitude comparator.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Result vector ordering is {eq, gt, lt}.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

endpackage : serial_cmp_pkg
`default_nettype wire

// File: rtl/cmp2_slice.sv
`default_nettype none
// ============================================================================
// Module      : cmp2_slice
// Description : Gate-level 2-bit magnitude comparator (eq / gt / lt).
// Revision    : 1.0 - initial release
// ============================================================================
module cmp2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       eq,
    output logic       gt,
    output logic       lt
);

    logic w_e1;
    logic w_e0;

    assign w_e1 = ~(a[1] ^ b[1]);
    assign w_e0 = ~(a[0] ^ b[0]);

    assign eq = w_e1 & w_e0;
    assign gt = (a[1] & ~b[1]) | (w_e1 & a[0] & ~b[0]);
    assign lt = (~a[1] & b[1]) | (w_e1 & ~a[0] & b[0]);

endmodule : cmp2_slice
`default_nettype wire

// File: rtl/serial_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module      : serial_mag_comparator
// Description : Compares two WIDTH-bit operands two bits per cycle, MSB first.
//               Optional macro SERIAL_CMP_EARLY_EXIT_EN ends the run on the
//               first unequal slice.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mag_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int              IDX_W    = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH / 2 - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             decided_q, decided_d;
    logic [1:0]       gl_q, gl_d;        // recorded {gt, lt} of the deciding slice
    logic [2:0]       res_q, res_d;

    logic [1:0] w_a_slice;
    logic [1:0] w_b_slice;
    logic       w_s_eq;
    logic       w_s_gt;
    logic       w_s_lt;
    logic       w_first_diff;
    logic       w_decided_now;
    logic [1:0] w_gl_now;
    logic       w_finish;

    assign w_a_slice = a_q[{idx_q, 1'b0} +: 2];
    assign w_b_slice = b_q[{idx_q, 1'b0} +: 2];

    cmp2_slice u_slice (
        .a  (w_a_slice),
        .b  (w_b_slice),
        .eq (w_s_eq),
        .gt (w_s_gt),
        .lt (w_s_lt)
    );

    assign w_first_diff  = ~decided_q & ~w_s_eq;
    assign w_decided_now = decided_q | ~w_s_eq;
    assign w_gl_now      = decided_q ? gl_q : {w_s_gt, w_s_lt};

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign w_finish = (idx_q == '0) | w_first_diff;
`else
    assign w_finish = (idx_q == '0);
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        gl_d      = gl_q;
        res_d     = res_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    idx_d     = LAST_IDX;
                    decided_d = 1'b0;
                    gl_d      = 2'b00;
                    state_d   = ST_RUN;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_first_diff) begin
                    decided_d = 1'b1;
                    gl_d      = {w_s_gt, w_s_lt};
                end
                if (w_finish) begin
                    state_d = ST_DONE;
                    res_d   = w_decided_now ? {1'b0, w_gl_now} : RES_EQ;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            gl_q      <= 2'b00;
            res_q     <= RES_NONE;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            gl_q      <= gl_d;
            res_q     <= res_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign eq   = res_q[2];
    assign gt   = res_q[1];
    assign lt   = res_q[0];

endmodule : serial_mag_comparator
`default_nettype wire
